// File: rtl/kmap_sweep_checker_pkg.sv
// Shared FSM encoding, default masks and the minterm classification helper
// for kmap_sweep_checker.
package kmap_sweep_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [15:0] DEF_ON_MASK       = 16'h058F;
  localparam logic [15:0] DEF_OFF_MASK      = 16'h7210;
  localparam int unsigned DEF_SETTLE_CYCLES = 2;

  // OFF takes priority over ON when a minterm appears in both masks.
  function automatic logic minterm_mismatch(input logic [15:0] on_mask,
                                            input logic [15:0] off_mask,
                                            input logic [3:0]  idx,
                                            input logic        f);
    logic is_off;
    logic is_on;
    is_off = off_mask[idx];
    is_on  = on_mask[idx] & ~is_off;
    return (is_on & ~f) | (is_off & f);
  endfunction

endpackage

// File: rtl/kmap_sweep_checker_if.sv
// Sweep-checker bus: start/f towards the checker, vector and results back.
// The first_fail signals exist only with KMAP_SWEEP_FIRST_FAIL_EN defined.
interface kmap_sweep_checker_if;

  logic       start;
  logic       f;
  logic [3:0] abcd;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_count;
`ifdef KMAP_SWEEP_FIRST_FAIL_EN
  logic [3:0] first_fail;
  logic       first_fail_valid;

  modport master (input start, input f,
                  output abcd, output busy, output done, output pass, output err_count,
                  output first_fail, output first_fail_valid);
  modport slave  (output start, output f,
                  input abcd, input busy, input done, input pass, input err_count,
                  input first_fail, input first_fail_valid);
`else
  modport master (input start, input f,
                  output abcd, output busy, output done, output pass, output err_count);
  modport slave  (output start, output f,
                  input abcd, input busy, input done, input pass, input err_count);
`endif

endinterface

// File: rtl/kmap_sweep_checker_settle_timer.sv
// Settle timer: counts cycles while not cleared, expires on the last
// settle cycle of the current vector.
module settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic expire_o
);

  localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    if (clear_i) begin
      cnt_d = 4'd0;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/kmap_sweep_checker.sv
// Sweeps minterms 0..15 onto a 4-input function, samples f after a settle
// time and counts ON/OFF mismatches. Optional KMAP_SWEEP_FIRST_FAIL_EN.
module kmap_sweep_checker
  import kmap_sweep_checker_pkg::*;
#(
  parameter logic [15:0] ON_MASK       = DEF_ON_MASK,
  parameter logic [15:0] OFF_MASK      = DEF_OFF_MASK,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  kmap_sweep_checker_if.master bus
);

  state_e     state_q;
  logic [3:0] idx_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [4:0] err_q;
  logic       settle_expire;
  logic       mismatch_d;
`ifdef KMAP_SWEEP_FIRST_FAIL_EN
  logic [3:0] ff_idx_q;
  logic       ff_valid_q;
`endif

  settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_q != ST_SETTLE),
    .expire_o (settle_expire)
  );

  assign mismatch_d = minterm_mismatch(ON_MASK, OFF_MASK, idx_q, bus.f);

  // Sweep FSM; idx_q doubles as the driven vector, outputs all registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= 5'd0;
`ifdef KMAP_SWEEP_FIRST_FAIL_EN
      ff_idx_q   <= 4'd0;
      ff_valid_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          idx_q      <= 4'd0;
          err_q      <= 5'd0;
          pass_q     <= 1'b0;
`ifdef KMAP_SWEEP_FIRST_FAIL_EN
          ff_idx_q   <= 4'd0;
          ff_valid_q <= 1'b0;
`endif
          state_q    <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_expire) begin
            state_q <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (mismatch_d) begin
            err_q <= err_q + 5'd1;
`ifdef KMAP_SWEEP_FIRST_FAIL_EN
            if (!ff_valid_q) begin
              ff_idx_q   <= idx_q;
              ff_valid_q <= 1'b1;
            end
`endif
          end
          if (idx_q == 4'd15) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
          end else begin
            idx_q   <= idx_q + 4'd1;
            state_q <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          pass_q  <= (err_q == 5'd0);
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.abcd      = idx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
`ifdef KMAP_SWEEP_FIRST_FAIL_EN
  assign bus.first_fail       = ff_idx_q;
  assign bus.first_fail_valid = ff_valid_q;
`endif

endmodule

// File: tb/tb_kmap_sweep_checker.sv
// Randomized bench for kmap_sweep_checker: two instances (default masks and
// overlapping masks), expectations from a truth-table reference model.
`timescale 1ns/1ps
module tb_kmap_sweep_checker;

  localparam logic [15:0] ON0  = 16'h058F;
  localparam logic [15:0] OFF0 = 16'h7210;
  localparam int          S0   = 2;
  localparam logic [15:0] ON1  = 16'h0001;
  localparam logic [15:0] OFF1 = 16'h0001;
  localparam int          S1   = 1;

  logic clk = 1'b0;
  logic rst;
  logic start0;
  logic start1;
  logic [15:0] tt;  // bit i = value of f for minterm i
  int sel;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  kmap_sweep_checker_if bus0 ();
  kmap_sweep_checker_if bus1 ();

  assign bus0.start = start0;
  assign bus0.f     = tt[bus0.abcd];
  assign bus1.start = start1;
  assign bus1.f     = tt[bus1.abcd];

  kmap_sweep_checker #(.ON_MASK(ON0), .OFF_MASK(OFF0), .SETTLE_CYCLES(S0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  kmap_sweep_checker #(.ON_MASK(ON1), .OFF_MASK(OFF1), .SETTLE_CYCLES(S1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  logic [3:0] o_abcd;
  logic       o_busy;
  logic       o_done;
  logic       o_pass;
  logic [4:0] o_err;
`ifdef KMAP_SWEEP_FIRST_FAIL_EN
  logic [3:0] o_ff;
  logic       o_ffv;
`endif

  always_comb begin
    if (sel == 1) begin
      o_abcd = bus1.abcd; o_busy = bus1.busy; o_done = bus1.done;
      o_pass = bus1.pass; o_err = bus1.err_count;
`ifdef KMAP_SWEEP_FIRST_FAIL_EN
      o_ff = bus1.first_fail; o_ffv = bus1.first_fail_valid;
`endif
    end else begin
      o_abcd = bus0.abcd; o_busy = bus0.busy; o_done = bus0.done;
      o_pass = bus0.pass; o_err = bus0.err_count;
`ifdef KMAP_SWEEP_FIRST_FAIL_EN
      o_ff = bus0.first_fail; o_ffv = bus0.first_fail_valid;
`endif
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] cur_on();
    return (sel == 1) ? ON1 : ON0;
  endfunction

  function automatic logic [15:0] cur_off();
    return (sel == 1) ? OFF1 : OFF0;
  endfunction

  function automatic int cur_settle();
    return (sel == 1) ? S1 : S0;
  endfunction

  // Reference: -1 when minterm i is fine or DC, otherwise i.
  function automatic int bad_minterm(input int i, input logic [15:0] t);
    logic [15:0] on_m;
    logic [15:0] off_m;
    on_m  = cur_on();
    off_m = cur_off();
    if (off_m[i]) return (t[i] == 1'b1) ? i : -1;
    if (on_m[i])  return (t[i] == 1'b0) ? i : -1;
    return -1;
  endfunction

  function automatic int exp_errs(input logic [15:0] t);
    int n = 0;
    for (int i = 0; i < 16; i++) if (bad_minterm(i, t) >= 0) n++;
    return n;
  endfunction

  function automatic int exp_first(input logic [15:0] t);
    for (int i = 0; i < 16; i++) if (bad_minterm(i, t) >= 0) return i;
    return 0;
  endfunction

  // Correct implementation of the current masks, random on DC minterms.
  function automatic logic [15:0] good_tt();
    logic [15:0] t;
    logic [15:0] on_m;
    logic [15:0] off_m;
    on_m  = cur_on();
    off_m = cur_off();
    t = 16'($urandom);
    for (int i = 0; i < 16; i++) begin
      if (off_m[i])     t[i] = 1'b0;
      else if (on_m[i]) t[i] = 1'b1;
    end
    return t;
  endfunction

  task automatic drive_start(input logic v);
    if (sel == 1) start1 = v;
    else          start0 = v;
  endtask

  task automatic check_results(input string tag);
    int e;
    e = exp_errs(tt);
    check_eq({tag, "_err"}, 32'(o_err), e);
    check_eq({tag, "_pass"}, 32'(o_pass), (e == 0) ? 32'd1 : 32'd0);
`ifdef KMAP_SWEEP_FIRST_FAIL_EN
    check_eq({tag, "_ffv"}, 32'(o_ffv), (e != 0) ? 32'd1 : 32'd0);
    check_eq({tag, "_ff"}, 32'(o_ff), exp_first(tt));
`endif
  endtask

  task automatic run_sweep(input string tag);
    int lat;
    int k;
    int nvis;
    int last;
    int done_k;
    bit seq_ok;
    lat = 2 + 16 * (cur_settle() + 1);
    @(negedge clk);
    drive_start(1'b1);
    @(posedge clk);
    @(negedge clk);
    drive_start(1'b0);
    check_eq({tag, "_busy_rise"}, 32'(o_busy), 32'd1);
    k = 0; nvis = 0; last = -1; done_k = -1; seq_ok = 1'b1;
    while (done_k < 0 && k < lat + 20) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (o_busy && int'(o_abcd) != last) begin
        if (int'(o_abcd) != nvis) seq_ok = 1'b0;
        nvis++;
        last = int'(o_abcd);
      end
      if (o_done) done_k = k;
    end
    check_eq({tag, "_done_edge"}, done_k, lat);
    check_eq({tag, "_abcd_seq"}, seq_ok ? nvis : 99, 32'd16);
    check_eq({tag, "_busy_at_done"}, 32'(o_busy), 32'd0);
    check_results(tag);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, 32'(o_done), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_abcd"}, 32'(o_abcd), 32'd0);
    check_eq({tag, "_busy"}, 32'(o_busy), 32'd0);
    check_eq({tag, "_done"}, 32'(o_done), 32'd0);
    check_eq({tag, "_pass"}, 32'(o_pass), 32'd0);
    check_eq({tag, "_err"}, 32'(o_err), 32'd0);
`ifdef KMAP_SWEEP_FIRST_FAIL_EN
    check_eq({tag, "_ffv"}, 32'(o_ffv), 32'd0);
    check_eq({tag, "_ff"}, 32'(o_ff), 32'd0);
`endif
  endtask

  initial begin
    int k;
    int seen;
    int ndone;
    int last_done;
    bit prev_done;

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; tt = 16'h0000; sel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("reset0");
    sel = 1; #1;
    check_reset_vals("reset1");
    sel = 0; #1;

    for (int r = 0; r < 3; r++) begin
      tt = good_tt();
      run_sweep("good");
    end
    tt = 16'h0000;
    run_sweep("stuck0");
    check_eq("stuck0_count", 32'(o_err), 32'd7);
    tt = 16'hFFFF;
    run_sweep("stuck1");
    check_eq("stuck1_count", 32'(o_err), 32'd5);
    for (int r = 0; r < 4; r++) begin
      tt = 16'($urandom);
      run_sweep("rand");
    end

    // Reset mid-sweep while the vector is 6.
    tt = good_tt();
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    k = 0;
    while (o_abcd != 4'd6 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq("rst_reach6", 32'(o_abcd), 32'd6);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("rst_mid");
    seen = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (o_done || o_busy) seen++;
    end
    check_eq("rst_no_activity", seen, 32'd0);
    run_sweep("after_rst");

    // Start held high: back-to-back sweeps, one IDLE cycle between them.
    tt = 16'($urandom);
    @(negedge clk);
    start0 = 1'b1;
    ndone = 0; last_done = -1; prev_done = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (prev_done) check_eq("held_reload", 32'(o_busy), 32'd1);
      prev_done = o_done;
      if (o_done) begin
        ndone++;
        check_eq("held_busy_at_done", 32'(o_busy), 32'd0);
        if (last_done >= 0) check_eq("held_period", c - last_done, 2 + 16 * (S0 + 1) + 1);
        last_done = c;
        check_results("held");
      end
    end
    check_eq("held_sweeps", ndone, 32'd3);
    start0 = 1'b0;
    repeat (60) @(negedge clk);

    // Overlapping masks on the second instance.
    sel = 1; #1;
    tt = 16'hFFFF;
    run_sweep("ovl_stuck1");
    check_eq("ovl_count", 32'(o_err), 32'd1);
    tt = good_tt();
    run_sweep("ovl_good");
    for (int r = 0; r < 2; r++) begin
      tt = 16'($urandom);
      run_sweep("ovl_rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
